sqr_seq: RTL

- Sequential bit-by-bit squarer; the inverse of the team's sequential square-root unit.
- Reconstructs x_out = x_in*x_in + r_in, one root bit per cycle, using the same start/finish idle-level handshake as the root unit so the two can be chained.
- The result saturates at all-ones on overflow.
- Sits beside the root unit in the VGA pixel math path, where radial distances are squared back for shading and compare.

---
 rtl/sqr_seq_pkg.sv | 22 ++
 rtl/sqr_seq_sat_add_unsigned.sv | 25 ++
 rtl/sqr_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/sqr_seq_pkg.sv
// Pixel-math package shared by the sequential square-root and squarer units:
// default operand width, half-width helper, all-ones helper and FSM states.
package sqr_seq_pkg;

    localparam int BIT_WIDTH_DEF = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Root width (and iteration count) for a given result width.
    function automatic int half_width(input int w);
        return w / 2;
    endfunction

    // All-ones pattern in the low w bits; callers cast it to their width.
    function automatic logic [63:0] all_ones(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/sqr_seq_sat_add_unsigned.sv
// W-bit unsigned adder that clamps to all ones on carry-out and reports
// the carry, so callers can keep a sticky overflow flag.
module sat_add_unsigned #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] raw;

    function automatic logic [W-1:0] saturate(input logic [W:0] full);
        return full[W] ? {W{1'b1}} : full[W-1:0];
    endfunction

    // Full-width add, then clamp on carry-out.
    always_comb begin
        raw   = {1'b0, a} + {1'b0, b};
        carry = raw[W];
        sum   = saturate(raw);
    end

endmodule

// File: rtl/sqr_seq.sv
// Sequential squarer: x_out = x_in*x_in + r_in, one root bit per cycle,
// MSB first, saturating to all ones. finish is the idle level shared with
// the square-root unit so the two can be chained.
module sqr_seq
    import sqr_seq_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] x_in,
    input  logic [BIT_WIDTH-1:0] r_in,
    input  logic                 start,
    output logic [BIT_WIDTH-1:0] x_out,
    output logic                 finish,
    output logic                 done,
    output logic                 overflow
);

    localparam int H  = half_width(BIT_WIDTH);
    localparam int IW = ($clog2(H) < 1) ? 1 : $clog2(H);
    localparam logic [BIT_WIDTH-1:0] ONES = BIT_WIDTH'(all_ones(BIT_WIDTH));

    state_t               state, state_nxt;
    logic [BIT_WIDTH-1:0] acc, acc_nxt;
    logic [H-1:0]         root, root_nxt;
    logic [IW-1:0]        i, i_nxt;
    logic                 ovf, ovf_nxt;
    logic                 done_r, done_nxt;

    logic [BIT_WIDTH-1:0] addend;
    logic [BIT_WIDTH-1:0] sum_sat;
    logic                 carry;

    // Partial product for the current root bit: root << i when root[i] is set.
    // root < 2^H and i < H, so the shifted value always fits BIT_WIDTH bits.
    always_comb begin
        addend = '0;
        if (root[i]) begin
            addend = BIT_WIDTH'(root) << i;
        end
    end

    sat_add_unsigned #(
        .W(BIT_WIDTH)
    ) u_acc_add (
        .a     (acc),
        .b     (addend),
        .sum   (sum_sat),
        .carry (carry)
    );

    // State, accumulator, root latch, bit index, sticky overflow and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            acc    <= '0;
            root   <= '0;
            i      <= '0;
            ovf    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            root   <= root_nxt;
            i      <= i_nxt;
            ovf    <= ovf_nxt;
            done_r <= done_nxt;
        end
    end

    // Next-state: accept start only while idle, then H accumulate steps.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        root_nxt  = root;
        i_nxt     = i;
        ovf_nxt   = ovf;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    root_nxt  = x_in[H-1:0];
                    i_nxt     = IW'(H - 1);
                    // A nonzero upper half means x_in >= 2^H, so the square
                    // cannot fit: preset the saturated result.
                    if (x_in[BIT_WIDTH-1:H] != '0) begin
                        acc_nxt = ONES;
                        ovf_nxt = 1'b1;
                    end else begin
                        acc_nxt = r_in;
                        ovf_nxt = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (ovf) begin
                    acc_nxt = ONES;
                end else begin
                    acc_nxt = sum_sat;
                    ovf_nxt = carry;
                end
                i_nxt = i - IW'(1);
                if (i == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign x_out    = acc;
    assign overflow = ovf;
    assign done     = done_r;
    assign finish   = (state == ST_IDLE);

endmodule
